hamming74_rx_ctrl: RTL

Sequencer for the shared serial Hamming(7,4) decoder in the UART receive path. It detects UART-style frames on the serial line, feeds the 7 code bits into the decoder one bit per enable pulse, and issues the extra flush pulse that makes the decoder emit a nibble. It pairs successive decoded nibbles into bytes and presents them on a valid/ready output with overrun and framing-error reporting.

---
 rtl/hamming74_rx_ctrl_if.sv | 23 ++
 rtl/hamming74_rx_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/hamming74_rx_ctrl_if.sv
// hamming74_rx_ctrl_if: decoder-side and byte-side buses of the Hamming(7,4) receive sequencer
interface hamming74_rx_ctrl_if;
   logic       dec_ena;
   logic       dec_bit;
   logic       dec_rst_n;
   logic       dec_valid;
   logic [3:0] dec_nibble;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic       overrun;
   logic       frame_err;
   logic       dec_timeout;
   logic       half_full;
   modport master (
      output dec_ena, dec_bit, dec_rst_n, byte_valid, byte_data, overrun, frame_err, dec_timeout, half_full,
      input  dec_valid, dec_nibble, byte_ready
   );
   modport slave (
      input  dec_ena, dec_bit, dec_rst_n, byte_valid, byte_data, overrun, frame_err, dec_timeout, half_full,
      output dec_valid, dec_nibble, byte_ready
   );
endinterface

// File: rtl/hamming74_rx_ctrl.sv
// hamming74_rx_ctrl: feeds framed serial code bits into the shared Hamming(7,4) decoder and pairs nibbles into bytes
module hamming74_rx_ctrl #(
   parameter int DEC_TIMEOUT = 4,
   parameter bit HIGH_FIRST  = 1'b0
) (
   input logic clk,
   input logic rst,
   input logic rx_in,
   input logic baud_tick,
   hamming74_rx_ctrl_if.master bus
);
   localparam int TW = $clog2(DEC_TIMEOUT + 1);
   // timeout fires in the DEC_TIMEOUT-th WAIT_DEC cycle, i.e. DEC_TIMEOUT cycles after the flush
   localparam logic [TW-1:0] T_LAST = TW'(DEC_TIMEOUT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, FLUSH, WAIT_DEC, STOP} state_t;
   state_t state, nxt;
   logic [2:0] idx;
   logic [TW-1:0] tcnt;
   logic [3:0] nib, held;
   logic have_nib, commit, abort;
   logic [7:0] formed;
   always_ff @(posedge clk)
      state <= rst ? IDLE : nxt;
   always_comb begin
      nxt             = state;
      bus.dec_ena     = 1'b0;
      bus.dec_bit     = 1'b0;
      bus.frame_err   = 1'b0;
      bus.dec_timeout = 1'b0;
      commit          = 1'b0;
      case (state)
         IDLE:  if (baud_tick && !rx_in) nxt = START;
         START: nxt = DATA;
         DATA:  if (baud_tick) begin
            bus.dec_ena = 1'b1;
            bus.dec_bit = rx_in;
            nxt         = idx == 3'd6 ? FLUSH : DATA;
         end
         FLUSH: begin
            bus.dec_ena = 1'b1;
            nxt         = WAIT_DEC;
         end
         WAIT_DEC: if (bus.dec_valid) nxt = STOP;
            else if (tcnt == T_LAST) begin
               bus.dec_timeout = 1'b1;
               nxt             = STOP;
            end
         STOP: if (baud_tick) begin
            bus.frame_err = !rx_in;
            commit        = rx_in && have_nib;
            nxt           = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end
   assign abort  = bus.frame_err | bus.dec_timeout;
   assign formed = HIGH_FIRST ? {held, nib} : {nib, held};
   always_ff @(posedge clk) begin
      if (rst) begin
         idx            <= '0;
         tcnt           <= '0;
         nib            <= '0;
         held           <= '0;
         have_nib       <= 1'b0;
         bus.dec_rst_n  <= 1'b0;
         bus.half_full  <= 1'b0;
         bus.byte_valid <= 1'b0;
         bus.byte_data  <= '0;
         bus.overrun    <= 1'b0;
      end else begin
         bus.dec_rst_n <= !abort;
         if (state == START) idx <= '0;
         else if (state == DATA && baud_tick) idx <= idx + 3'd1;
         if (state == FLUSH) begin
            tcnt     <= '0;
            have_nib <= 1'b0;
         end else if (state == WAIT_DEC) begin
            tcnt <= tcnt + 1'b1;
            if (bus.dec_valid) begin
               nib      <= bus.dec_nibble;
               have_nib <= 1'b1;
            end
         end
         if (bus.byte_valid && bus.byte_ready) bus.byte_valid <= 1'b0;
         if (abort) bus.half_full <= 1'b0;
         else if (commit && !bus.half_full) begin
            held          <= nib;
            bus.half_full <= 1'b1;
         end else if (commit) begin
            bus.half_full <= 1'b0;
            if (!bus.byte_valid || bus.byte_ready) begin
               bus.byte_data  <= formed;
               bus.byte_valid <= 1'b1;
            end else bus.overrun <= 1'b1;
         end
      end
   end
endmodule
